// File: rtl/fpnew_divsqrt_iter_core.sv
// Iterative radix-2 mantissa divide / square-root engine: one result bit per cycle,
// restoring algorithm, produces RES_W quotient/root bits plus a sticky bit.
module fpnew_divsqrt_iter_core #(
  parameter int unsigned MANT_WIDTH = 53
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  div_start_i,
  input  logic                  sqrt_start_i,
  input  logic                  kill_i,
  input  logic [MANT_WIDTH-1:0] mant_a_i,
  input  logic [MANT_WIDTH-1:0] mant_b_i,
  input  logic                  exp_odd_i,
  output logic [MANT_WIDTH+1:0] result_o,
  output logic                  sticky_o,
  output logic                  is_sqrt_o,
  output logic                  ready_o,
  output logic                  done_o
);

  localparam int unsigned RES_W = MANT_WIDTH + 2;
  localparam int unsigned REM_W = RES_W + 2;
  localparam int unsigned RAD_W = 2 * RES_W;
  localparam int unsigned CNT_W = $clog2(RES_W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [REM_W-1:0]   rem_reg;
  logic [RAD_W-1:0]   rad_reg;
  logic [MANT_WIDTH-1:0] b_reg;
  logic [RES_W-1:0]   acc_reg;
  logic               is_sqrt_op_reg;
  logic [RES_W-1:0]   result_reg;
  logic               sticky_reg;
  logic               is_sqrt_reg;

  logic               start_accept;
  logic               finish;

  logic [REM_W-1:0]   b_ext;
  logic               div_ge;
  logic [REM_W-1:0]   div_rem;
  logic [REM_W-1:0]   sq_shift;
  logic [REM_W-1:0]   sq_trial;
  logic               sq_ge;
  logic [REM_W-1:0]   sq_rem;
  logic               bit_next;
  logic [REM_W-1:0]   rem_next;
  logic [RES_W-1:0]   acc_next;

  // Control: kill has priority over everything, including starts in the same cycle.
  always_comb begin
    state_next   = state_reg;
    ready_o      = 1'b0;
    done_o       = 1'b0;
    start_accept = 1'b0;
    finish       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (!kill_i && (div_start_i || sqrt_start_i)) begin
          start_accept = 1'b1;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == CNT_W'(1)) begin
          state_next = DONE;
          finish     = !kill_i;
        end
      end
      DONE: begin
        ready_o = 1'b1;
        done_o  = !kill_i;
        if (!kill_i && (div_start_i || sqrt_start_i)) begin
          start_accept = 1'b1;
          state_next   = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (kill_i) state_next = IDLE;
  end

  // One restoring step of either algorithm; the accumulator doubles as quotient and root.
  always_comb begin
    b_ext    = REM_W'(b_reg);
    div_ge   = rem_reg >= b_ext;
    div_rem  = (div_ge ? (rem_reg - b_ext) : rem_reg) << 1;
    sq_shift = {rem_reg[REM_W-3:0], rad_reg[RAD_W-1 -: 2]};
    sq_trial = {acc_reg, 2'b01};
    sq_ge    = sq_shift >= sq_trial;
    sq_rem   = sq_ge ? (sq_shift - sq_trial) : sq_shift;
    bit_next = is_sqrt_op_reg ? sq_ge : div_ge;
    rem_next = is_sqrt_op_reg ? sq_rem : div_rem;
    acc_next = {acc_reg[RES_W-2:0], bit_next};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      rem_reg        <= '0;
      rad_reg        <= '0;
      b_reg          <= '0;
      acc_reg        <= '0;
      is_sqrt_op_reg <= 1'b0;
      result_reg     <= '0;
      sticky_reg     <= 1'b0;
      is_sqrt_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_accept) begin
        cnt_reg        <= CNT_W'(RES_W);
        acc_reg        <= '0;
        b_reg          <= mant_b_i;
        is_sqrt_op_reg <= !div_start_i;
        if (div_start_i) begin
          rem_reg <= REM_W'(mant_a_i);
          rad_reg <= '0;
        end else begin
          rem_reg <= '0;
          // Radicand in [1,4) with a 2-bit integer field, padded to 2*RES_W bits.
          rad_reg <= {(exp_odd_i ? {mant_a_i, 1'b0} : {1'b0, mant_a_i}), {(MANT_WIDTH + 3){1'b0}}};
        end
      end else if (state_reg == BUSY) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
        rem_reg <= rem_next;
        rad_reg <= {rad_reg[RAD_W-3:0], 2'b00};
        acc_reg <= acc_next;
      end
      if (finish) begin
        result_reg  <= acc_next;
        sticky_reg  <= |rem_next;
        is_sqrt_reg <= is_sqrt_op_reg;
      end
    end
  end

  assign result_o  = result_reg;
  assign sticky_o  = sticky_reg;
  assign is_sqrt_o = is_sqrt_reg;

endmodule

// File: tb/tb_fpnew_divsqrt_iter_core.sv
// Directed bench for fpnew_divsqrt_iter_core at MANT_WIDTH=4 (RES_W=6, done in cycle 7).
module tb_fpnew_divsqrt_iter_core;

  localparam int MW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          div_start_i = 1'b0;
  logic          sqrt_start_i = 1'b0;
  logic          kill_i = 1'b0;
  logic [MW-1:0] mant_a_i = '0;
  logic [MW-1:0] mant_b_i = '0;
  logic          exp_odd_i = 1'b0;
  logic [MW+1:0] result_o;
  logic          sticky_o;
  logic          is_sqrt_o;
  logic          ready_o;
  logic          done_o;

  int n_checks = 0;
  int n_fail   = 0;

  fpnew_divsqrt_iter_core #(.MANT_WIDTH(MW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .div_start_i(div_start_i), .sqrt_start_i(sqrt_start_i),
    .kill_i(kill_i), .mant_a_i(mant_a_i), .mant_b_i(mant_b_i), .exp_odd_i(exp_odd_i),
    .result_o(result_o), .sticky_o(sticky_o), .is_sqrt_o(is_sqrt_o),
    .ready_o(ready_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive a start for exactly one cycle (cycle 0); returns just after the edge that sampled it.
  task automatic launch(input logic dv, input logic sq, input logic [MW-1:0] a,
                        input logic [MW-1:0] b, input logic odd);
    @(posedge clk_i); #1;
    div_start_i = dv; sqrt_start_i = sq; mant_a_i = a; mant_b_i = b; exp_odd_i = odd;
    @(posedge clk_i); #1;
    div_start_i = 1'b0; sqrt_start_i = 1'b0;
  endtask

  // Returns the cycle index (relative to the start cycle) of the first done_o, or -1.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      if (done_o) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    n_checks += 5;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
    if (result_o !== 6'b0) begin n_fail++; $display("FAIL reset_result got=%b exp=000000", result_o); end
    if (sticky_o !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got=%b exp=0", sticky_o); end
    if (is_sqrt_o !== 1'b0) begin n_fail++; $display("FAIL reset_is_sqrt got=%b exp=0", is_sqrt_o); end
    $display("reset: ready=%b done=%b result=%b", ready_o, done_o, result_o);
    rst_ni = 1'b1;
  endtask

  task automatic test_div;
    logic [MW-1:0] a_v [2] = '{4'b1100, 4'b1000};
    logic [MW-1:0] b_v [2] = '{4'b1000, 4'b1100};
    logic [5:0]    r_v [2] = '{6'b110000, 6'b010101};
    logic          s_v [2] = '{1'b0, 1'b1};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      launch(1'b1, 1'b0, a_v[i], b_v[i], 1'b0);
      wait_done(cyc);
      n_checks += 4;
      if (cyc !== 7) begin n_fail++; $display("FAIL div_latency[%0d] got=%0d exp=7", i, cyc); end
      if (result_o !== r_v[i]) begin n_fail++; $display("FAIL div_result[%0d] got=%b exp=%b", i, result_o, r_v[i]); end
      if (sticky_o !== s_v[i]) begin n_fail++; $display("FAIL div_sticky[%0d] got=%b exp=%b", i, sticky_o, s_v[i]); end
      if (is_sqrt_o !== 1'b0) begin n_fail++; $display("FAIL div_is_sqrt[%0d] got=%b exp=0", i, is_sqrt_o); end
      $display("div %b/%b: cyc=%0d result=%b sticky=%b", a_v[i], b_v[i], cyc, result_o, sticky_o);
    end
  endtask

  task automatic test_sqrt;
    logic [MW-1:0] a_v [3] = '{4'b1000, 4'b1000, 4'b1001};
    logic          o_v [3] = '{1'b0, 1'b1, 1'b1};
    logic [5:0]    r_v [3] = '{6'b100000, 6'b101101, 6'b110000};
    logic          s_v [3] = '{1'b0, 1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(1'b0, 1'b1, a_v[i], 4'b0000, o_v[i]);
      wait_done(cyc);
      n_checks += 4;
      if (cyc !== 7) begin n_fail++; $display("FAIL sqrt_latency[%0d] got=%0d exp=7", i, cyc); end
      if (result_o !== r_v[i]) begin n_fail++; $display("FAIL sqrt_result[%0d] got=%b exp=%b", i, result_o, r_v[i]); end
      if (sticky_o !== s_v[i]) begin n_fail++; $display("FAIL sqrt_sticky[%0d] got=%b exp=%b", i, sticky_o, s_v[i]); end
      if (is_sqrt_o !== 1'b1) begin n_fail++; $display("FAIL sqrt_is_sqrt[%0d] got=%b exp=1", i, is_sqrt_o); end
      $display("sqrt %b odd=%b: cyc=%0d result=%b sticky=%b", a_v[i], o_v[i], cyc, result_o, sticky_o);
    end
  endtask

  task automatic test_both_start;
    int cyc;
    launch(1'b1, 1'b1, 4'b1000, 4'b1100, 1'b1);
    wait_done(cyc);
    n_checks += 3;
    if (cyc !== 7) begin n_fail++; $display("FAIL both_latency got=%0d exp=7", cyc); end
    if (result_o !== 6'b010101) begin n_fail++; $display("FAIL both_result got=%b exp=010101", result_o); end
    if (is_sqrt_o !== 1'b0) begin n_fail++; $display("FAIL both_is_sqrt got=%b exp=0", is_sqrt_o); end
    $display("div+sqrt start: cyc=%0d result=%b is_sqrt=%b", cyc, result_o, is_sqrt_o);
  endtask

  task automatic test_kill;
    int cyc;
    launch(1'b0, 1'b1, 4'b1000, 4'b0000, 1'b1);   // now in cycle 1
    @(posedge clk_i); #1;                          // cycle 2
    @(posedge clk_i); #1;                          // cycle 3
    kill_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL kill_done_c3 got=%b exp=0", done_o); end
    @(posedge clk_i); #1;                          // cycle 4
    kill_i = 1'b0;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL kill_ready_c4 got=%b exp=1", ready_o); end
    wait_done(cyc);
    n_checks += 3;
    if (cyc !== -1) begin n_fail++; $display("FAIL kill_no_done got=%0d exp=-1", cyc); end
    if (result_o !== 6'b010101) begin n_fail++; $display("FAIL kill_result got=%b exp=010101", result_o); end
    if (is_sqrt_o !== 1'b0) begin n_fail++; $display("FAIL kill_is_sqrt got=%b exp=0", is_sqrt_o); end
    $display("kill in cycle 3: done_seen=%0d result=%b", cyc, result_o);
  endtask

  task automatic test_back_to_back;
    int cyc;
    launch(1'b1, 1'b0, 4'b1100, 4'b1000, 1'b0);
    wait_done(cyc);
    n_checks += 3;
    if (cyc !== 7) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=7", cyc); end
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done got=%b exp=1", ready_o); end
    if (result_o !== 6'b110000) begin n_fail++; $display("FAIL b2b_first_result got=%b exp=110000", result_o); end
    div_start_i = 1'b1; mant_a_i = 4'b1000; mant_b_i = 4'b1100;
    @(posedge clk_i); #1;
    div_start_i = 1'b0;
    wait_done(cyc);
    n_checks += 3;
    if (cyc !== 7) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=7", cyc); end
    if (result_o !== 6'b010101) begin n_fail++; $display("FAIL b2b_second_result got=%b exp=010101", result_o); end
    if (sticky_o !== 1'b1) begin n_fail++; $display("FAIL b2b_second_sticky got=%b exp=1", sticky_o); end
    $display("back-to-back: second cyc=%0d result=%b", cyc, result_o);
  endtask

  task automatic test_reset_mid;
    int cyc;
    launch(1'b0, 1'b1, 4'b1001, 4'b0000, 1'b1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    n_checks += 4;
    if (result_o !== 6'b0) begin n_fail++; $display("FAIL rstmid_result got=%b exp=000000", result_o); end
    if (sticky_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_sticky got=%b exp=0", sticky_o); end
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", ready_o); end
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got=%b exp=0", done_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    wait_done(cyc);
    n_checks++;
    if (cyc !== -1) begin n_fail++; $display("FAIL rstmid_no_done got=%0d exp=-1", cyc); end
    $display("reset mid-op: result=%b done_seen=%0d", result_o, cyc);
  endtask

  initial begin
    test_reset();
    test_div();
    test_sqrt();
    test_both_start();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
